// File: rtl/ubcse_seq_accumulator.sv
// Packet accumulator behind the 10-bit carry-select adder core.
// Pair sums are accumulated per in_last-delimited packet; the result is held until downstream takes it.
module ubcse_seq_accumulator #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_x,
  input  logic [9:0]       in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned OP_W   = 10;
  localparam int unsigned LO_W   = 5;
  localparam int unsigned HI_W   = OP_W - LO_W;
  localparam int unsigned SUM_W  = OP_W + 1;
  localparam int unsigned ACC_XW = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   x_q, x_d;
  logic [OP_W-1:0]   y_q, y_d;
  logic              s1_valid_q, s1_valid_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic              in_fire_c;
  logic [LO_W:0]     lo_sum_c;
  logic [HI_W:0]     hi_sum0_c;
  logic [HI_W:0]     hi_sum1_c;
  logic [SUM_W-1:0]  pair_sum_c;
  logic [ACC_XW-1:0] acc_sum_c;

  // Carry-select core: low half ripples, high half precomputed for both carries.
  always_comb begin
    lo_sum_c   = {1'b0, x_q[LO_W-1:0]} + {1'b0, y_q[LO_W-1:0]};
    hi_sum0_c  = {1'b0, x_q[OP_W-1:LO_W]} + {1'b0, y_q[OP_W-1:LO_W]};
    hi_sum1_c  = hi_sum0_c + (HI_W+1)'(1);
    pair_sum_c = lo_sum_c[LO_W] ? {hi_sum1_c, lo_sum_c[LO_W-1:0]}
                                : {hi_sum0_c, lo_sum_c[LO_W-1:0]};
    acc_sum_c  = {1'b0, acc_q} + ACC_XW'(pair_sum_c);
  end

  assign in_fire_c = in_valid && in_ready_q;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    s1_valid_d  = 1'b0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    if (in_fire_c) begin
      x_d        = in_x;
      y_d        = in_y;
      s1_valid_d = 1'b1;
    end

    if (s1_valid_q) begin
      acc_d = acc_sum_c[ACC_W-1:0];
      ovf_d = ovf_q | acc_sum_c[ACC_W];
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (in_fire_c) state_d = in_last ? S_DRAIN : S_ACCUM;
      end
      S_DRAIN: begin
        state_d     = S_HOLD;
        out_valid_d = 1'b1;
      end
      S_HOLD: begin
        if (out_ready) begin
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_ACCUM);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      s1_valid_q  <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      s1_valid_q  <= s1_valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ubcse_seq_accumulator.sv
// Self-checking bench for ubcse_seq_accumulator: vector table, directed corner sequences
// and randomized packets scored against a packet-total model.
module tb_ubcse_seq_accumulator;

  localparam int unsigned ACC_W = 16;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [9:0]       in_x = '0;
  logic [9:0]       in_y = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             busy;

  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  ubcse_seq_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf),
    .busy(busy)
  );

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] exp_sum;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic send_beat(input logic [9:0] x, input logic [9:0] y, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_y = y; in_last = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x = 10'($urandom); in_y = 10'($urandom); in_last = 1'($urandom);
  endtask

  // Waits for the result, checks it, optionally stalls, then consumes it.
  task automatic take_result(input string name, input logic [15:0] es, input logic [7:0] ec,
                             input logic eo, input int hold);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_valid", name), 32'(out_valid), 1);
    check($sformatf("%s_sum", name), 32'(out_sum), 32'(es));
    check($sformatf("%s_count", name), 32'(out_count), 32'(ec));
    check($sformatf("%s_ovf", name), 32'(out_ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold_valid", name), 32'(out_valid), 1);
      check($sformatf("%s_hold_sum", name), 32'(out_sum), 32'(es));
      check($sformatf("%s_hold_inrdy", name), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("%s_clr_valid", name), 32'(out_valid), 0);
    check($sformatf("%s_clr_busy", name), 32'(busy), 0);
    check($sformatf("%s_clr_inrdy", name), 32'(in_ready), 1);
    check($sformatf("%s_clr_sum", name), 32'(out_sum), 0);
    check($sformatf("%s_clr_count", name), 32'(out_count), 0);
    check($sformatf("%s_clr_ovf", name), 32'(out_ovf), 0);
  endtask

  task automatic check_reset_values(input string name);
    check($sformatf("%s_inrdy", name), 32'(in_ready), 1);
    check($sformatf("%s_valid", name), 32'(out_valid), 0);
    check($sformatf("%s_sum", name), 32'(out_sum), 0);
    check($sformatf("%s_count", name), 32'(out_count), 0);
    check($sformatf("%s_ovf", name), 32'(out_ovf), 0);
    check($sformatf("%s_busy", name), 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint unsigned total;
    int unsigned nb;
    logic [9:0] rx, ry;
    logic pre;

    vecs[0] = '{10'd1023, 10'd1023, 16'd2046};
    vecs[1] = '{10'd0,    10'd0,    16'd0};
    vecs[2] = '{10'd1,    10'd0,    16'd1};
    vecs[3] = '{10'd512,  10'd511,  16'd1023};
    vecs[4] = '{10'd1000, 10'd24,   16'd1024};
    vecs[5] = '{10'd0,    10'd1023, 16'd1023};

    // Reset
    repeat (3) @(negedge clk);
    check_reset_values("rst_hold");
    rst_n = 1'b1;
    #1;
    check_reset_values("rst_rel");

    // Single-beat latency: DRAIN after E0, out_valid at E0+1
    send_beat(10'd1023, 10'd1023, 1'b1);
    check("lat_drain_busy", 32'(busy), 1);
    check("lat_drain_inrdy", 32'(in_ready), 0);
    check("lat_drain_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_hold_valid", 32'(out_valid), 1);
    check("lat_hold_sum", 32'(out_sum), 2046);
    take_result("single", 16'd2046, 8'd1, 1'b0, 0);

    // Vector table of single-beat packets
    for (int i = 0; i < 6; i++) begin
      send_beat(vecs[i].x, vecs[i].y, 1'b1);
      take_result($sformatf("vec%0d", i), vecs[i].exp_sum, 8'd1, 1'b0, i % 2);
    end

    // Three beats with a two-cycle bubble
    send_beat(10'd1, 10'd2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("three_bubble_inrdy", 32'(in_ready), 1);
    check("three_bubble_busy", 32'(busy), 1);
    send_beat(10'd3, 10'd4, 1'b0);
    send_beat(10'd5, 10'd6, 1'b1);
    check("three_drain_inrdy", 32'(in_ready), 0);
    take_result("three", 16'd21, 8'd3, 1'b0, 2);

    // Accumulator wrap over 33 max beats, then a fresh packet
    for (int i = 0; i < 33; i++) send_beat(10'd1023, 10'd1023, 1'(i == 32));
    take_result("wrap", 16'd1982, 8'd33, 1'b1, 0);
    send_beat(10'd1, 10'd1, 1'b1);
    take_result("after_wrap", 16'd2, 8'd1, 1'b0, 0);

    // Backpressure for five cycles
    send_beat(10'd300, 10'd200, 1'b1);
    take_result("bp", 16'd500, 8'd1, 1'b0, 5);

    // Reset mid-ACCUM discards the packet
    send_beat(10'd100, 10'd100, 1'b0);
    send_beat(10'd100, 10'd100, 1'b0);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 1);
    check("midrst_count", 32'(out_count), 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(10'd7, 10'd8, 1'b1);
    take_result("post_rst", 16'd15, 8'd1, 1'b0, 0);

    // Random packets against the packet-total model
    for (int p = 0; p < 20; p++) begin
      nb = (p == 5) ? 260 : $urandom_range(1, 40);
      total = 0;
      for (int b = 0; b < int'(nb); b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        rx = 10'($urandom_range(0, 1023));
        ry = 10'($urandom_range(0, 1023));
        send_beat(rx, ry, 1'(b == int'(nb) - 1));
        total += longint'(rx) + longint'(ry);
      end
      pre = 1'($urandom_range(0, 1));
      if (pre) out_ready = 1'b1;
      take_result($sformatf("rnd%0d", p), 16'(total % 65536),
                  8'((nb > 255) ? 255 : nb), 1'(total >= 65536),
                  pre ? 0 : int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
